// File: rtl/char_mem_arb_pkg.sv
// char_mem_arb_pkg: shared types and defaults for the character-memory arbiter.
// Provides the read-return tag, default bus widths and the wait-counter width.
package char_mem_arb_pkg;
  localparam int DEF_ADDR_W = 12;
  localparam int DEF_DATA_W = 8;
  localparam int WAIT_W = 8;
  typedef enum logic [1:0] {RD_NONE, RD_DISP, RD_HOST} rd_tag_t;
endpackage

// File: rtl/char_mem_arbiter_if.sv
// char_mem_arbiter_if: display, host and RAM buses of the character-memory arbiter.
// slave: arbiter side (takes requests, drives RAM); master: requesters and RAM side.
interface char_mem_arbiter_if #(
  parameter int ADDR_W = char_mem_arb_pkg::DEF_ADDR_W,
  parameter int DATA_W = char_mem_arb_pkg::DEF_DATA_W
);
  logic              disp_valid;
  logic [ADDR_W-1:0] disp_addr;
  logic              disp_ready;
  logic [DATA_W-1:0] disp_rdata;
  logic              disp_rvalid;
  logic              disp_stall;
  logic              host_valid;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic              host_ready;
  logic [DATA_W-1:0] host_rdata;
  logic              host_rvalid;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  modport slave (
    input  disp_valid, disp_addr, host_valid, host_we, host_addr, host_wdata, mem_rdata,
    output disp_ready, disp_rdata, disp_rvalid, disp_stall,
           host_ready, host_rdata, host_rvalid,
           mem_en, mem_we, mem_addr, mem_wdata
  );
  modport master (
    output disp_valid, disp_addr, host_valid, host_we, host_addr, host_wdata, mem_rdata,
    input  disp_ready, disp_rdata, disp_rvalid, disp_stall,
           host_ready, host_rdata, host_rvalid,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/char_mem_arbiter.sv
// char_mem_arbiter: display-priority arbiter sharing one sync-read RAM with a host port.
// Ports: ACLK/ARESET (async, active-high); bus = display/host valid-ready requests,
// one-cycle rvalid returns, RAM issue signals and disp_stall on forced host slots.
module char_mem_arbiter
  import char_mem_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int HOST_MAX_WAIT = 15
) (
  input logic ACLK,
  input logic ARESET,
  char_mem_arbiter_if.slave bus
);
  logic [WAIT_W-1:0] wait_cnt;
  logic              force_host;
  logic              disp_xfer;
  logic              host_xfer;
  logic              mem_en_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  rd_tag_t           tag_issue;
  rd_tag_t           tag_ret;
  assign force_host = wait_cnt == WAIT_W'(HOST_MAX_WAIT);
  assign bus.disp_ready = bus.disp_valid && !(force_host && bus.host_valid);
  assign bus.host_ready = bus.host_valid && (!bus.disp_valid || force_host);
  assign bus.disp_stall = bus.disp_valid && force_host && bus.host_valid;
  assign disp_xfer = bus.disp_valid && bus.disp_ready;
  assign host_xfer = bus.host_valid && bus.host_ready;
  assign bus.mem_en = mem_en_q;
  assign bus.mem_we = mem_we_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  // RAM output is already registered, so the return tag only gates and steers it.
  assign bus.disp_rvalid = tag_ret == RD_DISP;
  assign bus.host_rvalid = tag_ret == RD_HOST;
  assign bus.disp_rdata = bus.disp_rvalid ? bus.mem_rdata : '0;
  assign bus.host_rdata = bus.host_rvalid ? bus.mem_rdata : '0;
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      wait_cnt    <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      tag_issue   <= RD_NONE;
      tag_ret     <= RD_NONE;
    end else begin
      wait_cnt    <= (bus.host_valid && !bus.host_ready) ? (force_host ? wait_cnt : wait_cnt + 1'b1) : '0;
      mem_en_q    <= disp_xfer || host_xfer;
      mem_we_q    <= host_xfer && bus.host_we;
      mem_addr_q  <= host_xfer ? bus.host_addr : disp_xfer ? bus.disp_addr : mem_addr_q;
      mem_wdata_q <= host_xfer ? bus.host_wdata : mem_wdata_q;
      tag_issue   <= (host_xfer && !bus.host_we) ? RD_HOST : disp_xfer ? RD_DISP : RD_NONE;
      tag_ret     <= tag_issue;
    end
  end
endmodule
